// File: rtl/dmem_arbiter_if.sv
// Shared data-RAM bus: CPU read/write port, VGA read-only port, RAM port and error flag.
// slave is the arbiter view; master is the requester/RAM environment view.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rd;
  logic        vga_req;
  logic [31:0] vga_addr;
  logic        vga_gnt;
  logic        vga_rvalid;
  logic [31:0] vga_rd;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        oob_err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd, vga_req, vga_addr, mem_rd,
    output cpu_gnt, cpu_rvalid, cpu_rd, vga_gnt, vga_rvalid, vga_rd,
           mem_we, mem_addr, mem_wd, oob_err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd, vga_req, vga_addr, mem_rd,
    input  cpu_gnt, cpu_rvalid, cpu_rd, vga_gnt, vga_rvalid, vga_rd,
           mem_we, mem_addr, mem_wd, oob_err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// CPU/VGA arbiter for one shared RAM; combinational grant, read data one cycle after grant.
// VGA wins contention; a CPU denied MAX_WAIT cycles is forced through; ungranted requests just wait.
module dmem_arbiter #(
  parameter int unsigned DEPTH    = 129600,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  dmem_arbiter_if.slave bus
);
  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, VGA = 2'd1, CPU = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            rd_pend_q, rd_pend_d;
  logic [31:0]     cpu_rd_q, vga_rd_q;
  logic            oob_q;

  logic            cpu_gnt, vga_gnt, oob, starve;
  logic [31:0]     gnt_addr, rd_load;

  always_comb begin
    cpu_gnt   = 1'b0;
    vga_gnt   = 1'b0;
    state_d   = IDLE;
    wait_d    = '0;
    gnt_addr  = '0;
    starve    = bus.cpu_req && (wait_q == WW'(MAX_WAIT));

    if (!reset) begin
      if (starve)            cpu_gnt = 1'b1;
      else if (bus.vga_req)  vga_gnt = 1'b1;
      else if (bus.cpu_req)  cpu_gnt = 1'b1;
    end

    if (vga_gnt)      state_d = VGA;
    else if (cpu_gnt) state_d = CPU;

    // Counter only survives while the CPU keeps asking and keeps losing.
    if (bus.cpu_req && !cpu_gnt)
      wait_d = starve ? wait_q : wait_q + 1'b1;

    if (cpu_gnt)      gnt_addr = bus.cpu_addr;
    else if (vga_gnt) gnt_addr = bus.vga_addr;

    oob       = (cpu_gnt || vga_gnt) && (gnt_addr >= 32'(DEPTH));
    rd_load   = oob ? 32'd0 : bus.mem_rd;
    rd_pend_d = vga_gnt || (cpu_gnt && !bus.cpu_we);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      rd_pend_q <= 1'b0;
      cpu_rd_q  <= '0;
      vga_rd_q  <= '0;
      oob_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      rd_pend_q <= rd_pend_d;
      if (cpu_gnt && !bus.cpu_we) cpu_rd_q <= rd_load;
      if (vga_gnt)                vga_rd_q <= rd_load;
      oob_q     <= oob_q | oob;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.vga_gnt    = vga_gnt;
  assign bus.mem_addr   = gnt_addr;
  assign bus.mem_we     = cpu_gnt && bus.cpu_we && !oob;
  assign bus.mem_wd     = bus.cpu_wd;
  // Reset in the cycle after a grant must hide the pending read result at once.
  assign bus.cpu_rvalid = !reset && rd_pend_q && (state_q == CPU);
  assign bus.vga_rvalid = !reset && rd_pend_q && (state_q == VGA);
  assign bus.cpu_rd     = reset ? 32'd0 : cpu_rd_q;
  assign bus.vga_rd     = reset ? 32'd0 : vga_rd_q;
  assign bus.oob_err    = oob_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small RAM model behind the memory port.
module tb_dmem_arbiter;
  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;
  logic [31:0] ram [256];
  int   oob_low;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.DEPTH(129600), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Out-of-range reads see junk so that zeroing by the arbiter is observable.
  assign bus.mem_rd = (bus.mem_addr < 32'd129600) ? ram[bus.mem_addr[7:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req  = 1'b0;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'd0;
    bus.cpu_wd   = 32'd0;
    bus.vga_req  = 1'b0;
    bus.vga_addr = 32'd0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'd0;
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    idle_inputs();
    reset = 1'b1;
    #1;

    // Requests during reset are ignored.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'd5; bus.vga_req = 1'b1;
    settle();
    chk("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    chk("rst_vga_gnt", 32'(bus.vga_gnt), 32'd0);
    chk("rst_mem_we",  32'(bus.mem_we),  32'd0);
    next(); next();
    idle_inputs();
    settle();
    chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("rst_vga_rvalid", 32'(bus.vga_rvalid), 32'd0);
    chk("rst_cpu_rd",     bus.cpu_rd,          32'd0);
    chk("rst_vga_rd",     bus.vga_rd,          32'd0);
    chk("rst_oob",        32'(bus.oob_err),    32'd0);
    chk("rst_wait",       32'(dut.wait_q),     32'd0);
    next();
    reset = 1'b0;

    // CPU-only write of 0xA5 to address 10.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'd10; bus.cpu_wd = 32'hA5;
    settle();
    chk("wr_cpu_gnt",  32'(bus.cpu_gnt), 32'd1);
    chk("wr_vga_gnt",  32'(bus.vga_gnt), 32'd0);
    chk("wr_mem_we",   32'(bus.mem_we),  32'd1);
    chk("wr_mem_addr", bus.mem_addr,     32'd10);
    chk("wr_mem_wd",   bus.mem_wd,       32'hA5);
    next();
    idle_inputs();
    settle();
    chk("wr_no_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("idle_mem_addr", bus.mem_addr,       32'd0);
    chk("idle_mem_we",  32'(bus.mem_we),     32'd0);
    next();

    // Read back address 10.
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'd10;
    settle();
    chk("rd_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    chk("rd_mem_we",  32'(bus.mem_we),  32'd0);
    next();
    idle_inputs();
    settle();
    chk("rd_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("rd_data",   bus.cpu_rd,          32'hA5);
    next();
    settle();
    chk("rd_rvalid_once", 32'(bus.cpu_rvalid), 32'd0);
    chk("rd_hold",        bus.cpu_rd,          32'hA5);
    next();

    // Contention for 8 cycles: VGA x4, forced CPU, then VGA again.
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'd10; bus.vga_req = 1'b1; bus.vga_addr = 32'd20;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("cont_vga_gnt",    32'(i != 4),             32'(bus.vga_gnt));
      chk("cont_cpu_gnt",    32'(bus.cpu_gnt),        32'(i == 4));
      chk("cont_cpu_rvalid", 32'(bus.cpu_rvalid),     32'(i == 5));
      chk("cont_vga_rvalid", 32'(bus.vga_rvalid),     32'(i >= 1 && i != 5));
      if (i == 5) chk("cont_cpu_rd", bus.cpu_rd, 32'hA5);
      next();
    end
    idle_inputs();
    next();

    // Withdrawn CPU request under constant VGA traffic.
    bus.vga_req = 1'b1; bus.cpu_req = 1'b1; bus.cpu_addr = 32'd11;
    settle(); chk("wd_cpu_gnt0", 32'(bus.cpu_gnt), 32'd0); next();
    settle(); chk("wd_cpu_gnt1", 32'(bus.cpu_gnt), 32'd0); next();
    bus.cpu_req = 1'b0;
    settle(); chk("wd_cpu_gnt2", 32'(bus.cpu_gnt), 32'd0); next();
    idle_inputs();
    settle();
    chk("wd_wait",   32'(dut.wait_q),     32'd0);
    chk("wd_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    next();

    // Out-of-range CPU write at exactly DEPTH.
    chk("oob_pre", 32'(bus.oob_err), 32'd0);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'd129600; bus.cpu_wd = 32'h77;
    settle();
    chk("oobw_gnt",    32'(bus.cpu_gnt), 32'd1);
    chk("oobw_mem_we", 32'(bus.mem_we),  32'd0);
    chk("oobw_oob_now", 32'(bus.oob_err), 32'd0);
    next();
    idle_inputs();
    oob_low = 0;
    for (int i = 0; i < 100; i++) begin
      settle();
      if (bus.oob_err !== 1'b1) oob_low++;
      next();
    end
    chk("oob_sticky_low_cycles", 32'(oob_low), 32'd0);
    reset = 1'b1;
    next();
    reset = 1'b0;
    settle();
    chk("oob_cleared", 32'(bus.oob_err), 32'd0);
    next();

    // Last in-range address is a normal write.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'd129599; bus.cpu_wd = 32'h12;
    settle();
    chk("edge_mem_we", 32'(bus.mem_we), 32'd1);
    next();
    idle_inputs();
    settle();
    chk("edge_oob", 32'(bus.oob_err), 32'd0);
    next();

    // Out-of-range VGA read returns zero.
    bus.vga_req = 1'b1; bus.vga_addr = 32'd200000;
    settle();
    chk("oobr_gnt",  32'(bus.vga_gnt), 32'd1);
    chk("oobr_addr", bus.mem_addr,     32'd200000);
    next();
    idle_inputs();
    settle();
    chk("oobr_rvalid", 32'(bus.vga_rvalid), 32'd1);
    chk("oobr_rd",     bus.vga_rd,          32'd0);
    chk("oobr_oob",    32'(bus.oob_err),    32'd1);
    next();

    // Reset in the cycle after a VGA read grant.
    bus.vga_req = 1'b1; bus.vga_addr = 32'd10;
    settle();
    chk("rmr_gnt", 32'(bus.vga_gnt), 32'd1);
    next();
    idle_inputs();
    reset = 1'b1;
    settle();
    chk("rmr_rvalid", 32'(bus.vga_rvalid), 32'd0);
    chk("rmr_rd",     bus.vga_rd,          32'd0);
    next();
    reset = 1'b0;
    settle();
    chk("rmr_state",   32'(dut.state_q),     32'd0);
    chk("rmr_rvalid2", 32'(bus.vga_rvalid),  32'd0);
    next();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
